// File: rtl/pc_sequencer_if.sv
// Purpose : fetch-sequencer bus bundle (hazard/redirect inputs, imem handshake, decode-side outputs).
// Ports   : master = pc_sequencer side, slave = pipeline/memory environment side.
// Notes   : purely combinational wiring, no clock inside the bundle.
interface pc_sequencer_if;
   logic        stall;
   logic        redirect_en;
   logic [31:0] redirect_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic        flush;
   logic        misaligned;
   logic [15:0] redirect_count;

   modport master (
      input  stall, redirect_en, redirect_addr, imem_ready,
      output imem_req, imem_addr, fetch_valid, fetch_pc, flush, misaligned, redirect_count
   );

   modport slave (
      output stall, redirect_en, redirect_addr, imem_ready,
      input  imem_req, imem_addr, fetch_valid, fetch_pc, flush, misaligned, redirect_count
   );
endinterface

// File: rtl/pc_sequencer.sv
// Purpose : program-counter sequencer; issues fetches, handles redirects/flush, halts on misaligned target.
// Latency : imem_req is combinational; fetch_valid/fetch_pc/flush/misaligned appear one cycle after the event.
// Backpressure: stall or a missing imem_ready holds the PC; redirects override both.
// Ports   : CLK, nRST (async active-low), bus (pc_sequencer_if.master).
module pc_sequencer #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic           CLK,
   input  logic           nRST,
   pc_sequencer_if.master bus
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   // Counter holds the number of flush cycles still to come after the current one.
   localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        fetch_valid_q, fetch_valid_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        flush_q, flush_d;
   logic        misaligned_q, misaligned_d;
   logic [15:0] redirect_count_q, redirect_count_d;
   logic [2:0]  flush_cnt_q, flush_cnt_d;

   logic        imem_req_c;
   logic        redirect_ok;
   logic        redirect_bad;
   logic        fetch_fire;

   assign redirect_ok  = bus.redirect_en && (bus.redirect_addr[1:0] == 2'b00);
   assign redirect_bad = bus.redirect_en && (bus.redirect_addr[1:0] != 2'b00);
   assign fetch_fire   = imem_req_c && bus.imem_ready;

   // State register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q          <= ST_FETCH;
         pc_q             <= RESET_PC;
         fetch_valid_q    <= 1'b0;
         fetch_pc_q       <= 32'h0;
         flush_q          <= 1'b0;
         misaligned_q     <= 1'b0;
         redirect_count_q <= 16'h0;
         flush_cnt_q      <= 3'd0;
      end else begin
         state_q          <= state_d;
         pc_q             <= pc_d;
         fetch_valid_q    <= fetch_valid_d;
         fetch_pc_q       <= fetch_pc_d;
         flush_q          <= flush_d;
         misaligned_q     <= misaligned_d;
         redirect_count_q <= redirect_count_d;
         flush_cnt_q      <= flush_cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d          = state_q;
      pc_d             = pc_q;
      fetch_valid_d    = 1'b0;
      fetch_pc_d       = fetch_pc_q;
      flush_d          = 1'b0;
      misaligned_d     = misaligned_q;
      redirect_count_d = redirect_count_q;
      flush_cnt_d      = flush_cnt_q;

      case (state_q)
         ST_FETCH, ST_FLUSH: begin
            // Redirects win over stall, over a same-cycle imem_ready and over an ongoing flush.
            if (redirect_bad) begin
               state_d      = ST_HALT;
               misaligned_d = 1'b1;
               flush_d      = 1'b1;
            end else if (redirect_ok) begin
               state_d     = ST_FLUSH;
               pc_d        = bus.redirect_addr;
               flush_d     = 1'b1;
               flush_cnt_d = FLUSH_RELOAD;
               if (redirect_count_q != 16'hFFFF) begin
                  redirect_count_d = redirect_count_q + 16'd1;
               end
            end else if (state_q == ST_FLUSH) begin
               // Flush drains regardless of stall.
               if (flush_cnt_q == 3'd0) begin
                  state_d = ST_FETCH;
               end else begin
                  flush_cnt_d = flush_cnt_q - 3'd1;
                  flush_d     = 1'b1;
               end
            end else if (fetch_fire) begin
               fetch_valid_d = 1'b1;
               fetch_pc_d    = pc_q;
               pc_d          = pc_q + 32'd4;   // wraps modulo 2^32
            end
         end
         ST_HALT: begin
            // Only reset leaves HALT; flush drops after its single cycle.
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // Output logic
   always_comb begin
      imem_req_c         = (state_q == ST_FETCH) && !bus.stall && !bus.redirect_en;
      bus.imem_req       = imem_req_c;
      bus.imem_addr      = pc_q;
      bus.fetch_valid    = fetch_valid_q;
      bus.fetch_pc       = fetch_pc_q;
      bus.flush          = flush_q;
      bus.misaligned     = misaligned_q;
      bus.redirect_count = redirect_count_q;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-002 Parameter FLUSH_CYCLES, default 2, legal range 1..7: cycles flush stays high after a redirect.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  downstream hazard stall; holds PC and blocks new fetch requests.
REQ-006 redirect_en  input  1  branch/jump taken, from the branch resolver next_addr_en.
REQ-007 redirect_addr  input  32  redirect target, from the branch resolver next_addr.
REQ-008 imem_req  output  1  instruction fetch request.
REQ-009 imem_addr  output  32  fetch address; always equals the PC register.
REQ-010 imem_ready  input  1  fetch accepted and completed this cycle.
REQ-011 fetch_valid  output  1  registered; fetched instruction valid for decode.
REQ-012 fetch_pc  output  32  registered; PC of the instruction marked by fetch_valid.
REQ-013 flush  output  1  registered; squash younger pipeline stages.
REQ-014 misaligned  output  1  registered, sticky; redirect target not word-aligned.
REQ-015 redirect_count  output  16  saturating count of accepted redirects.

Function
REQ-016 FSM states SHALL be FETCH, FLUSH and HALT; the reset state is FETCH.
REQ-017 imem_req SHALL equal (state==FETCH) && !stall && !redirect_en, combinationally.
REQ-018 In FETCH, when imem_req && imem_ready, the next cycle SHALL show fetch_valid=1, fetch_pc=old PC, and PC=old PC+4.
REQ-019 fetch_valid SHALL be 0 in every cycle not selected by REQ-018 (single-cycle pulse per accepted fetch).
REQ-020 PC+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-021 While stall=1 in FETCH, PC, fetch_pc and state SHALL hold, and fetch_valid SHALL be 0.
REQ-022 redirect_en=1 with redirect_addr[1:0]==0 in FETCH or FLUSH SHALL, next cycle: set PC=redirect_addr, state=FLUSH, flush=1, and flush counter=FLUSH_CYCLES-1.
REQ-023 A redirect SHALL take priority over stall and over a same-cycle imem_ready; that fetch is discarded (no fetch_valid).
REQ-024 In FLUSH, flush SHALL stay 1; the counter decrements each cycle, independent of stall; at counter==0 with no new redirect, the next state is FETCH and flush=0.
REQ-025 A redirect during FLUSH SHALL reload PC and restart the counter at FLUSH_CYCLES-1; flush stays 1 without a gap.
REQ-026 imem_ready in FLUSH or HALT SHALL be ignored.
REQ-027 redirect_en=1 with redirect_addr[1:0]!=0 SHALL move to HALT next cycle with misaligned=1, flush=1 for one cycle, and PC unchanged.
REQ-028 HALT SHALL be exited only by reset; imem_req=0, fetch_valid=0, and redirect_en is ignored.
REQ-029 redirect_count SHALL increment on each aligned redirect accepted per REQ-022 and saturate at 16'hFFFF.

Reset
REQ-030 Asserting nRST low SHALL immediately set: state=FETCH, PC=RESET_PC, fetch_valid=0, fetch_pc=0, flush=0, misaligned=0, redirect_count=0, flush counter=0.
REQ-031 Reset asserted mid-FLUSH or in HALT SHALL abandon the operation, with no residual flush after release.
REQ-032 First fetch request SHALL occur in the first cycle after nRST deasserts, with stall=0 and imem_addr=RESET_PC.

Verification
REQ-033 Reset release, stall=0, imem_ready=1 for 3 cycles -> fetch_pc sequence 0x0, 0x4, 0x8 with fetch_valid=1 each cycle.
REQ-034 PC=0x100, redirect_en=1, redirect_addr=0x200, imem_ready=1 same cycle -> no fetch_valid, flush=1 for 2 cycles, then imem_addr=0x200 and imem_req=1.
REQ-035 Redirect to 0x40 then redirect to 0x80 one cycle later -> flush high for 3 contiguous cycles, first post-flush fetch at 0x80, redirect_count=2.
REQ-036 PC=0xFFFF_FFFC with one accepted fetch -> fetch_pc=0xFFFF_FFFC, next imem_addr=0x0.
REQ-037 redirect_addr=0x202 -> misaligned=1 sticky, imem_req=0 thereafter; nRST pulse -> misaligned=0, imem_addr=RESET_PC.
REQ-038 stall=1 for 4 cycles with imem_ready=1 -> imem_req=0, PC held, fetch_valid=0; stall release -> fetch resumes at the same PC.
